inst_fetch: RTL

Instruction fetch stage that sits directly upstream of the decoder. It owns the program counter and issues word reads to a fixed-latency instruction BRAM. It buffers returned words with their PCs in a small FIFO and presents them to the decode/exec FSM through a valid/ready handshake. It also accepts PC redirects from the execute stage for branches and jumps, and flags misaligned redirect targets.

---
 rtl/inst_fetch.sv | 123 ++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage in front of the decoder.
// Owns the PC and issues word reads to a fixed-latency instruction BRAM.
// Returned words are queued with their PCs in a small FIFO and handed to
// decode through a valid/ready handshake. Execute-stage redirects flush the
// pipe. A misaligned redirect target raises a sticky fault that halts fetch
// until reset.
//
// Ports
//   clk, rstn        clock, synchronous active-low reset
//   imem_en          BRAM read request (combinational, 0 while rstn=0)
//   imem_addr        BRAM word address = pc_q[IMEM_ADDR_W+1:2]
//   imem_rdata       BRAM data, MEM_LATENCY cycles after the request
//   redirect_valid   execute requests a new PC (redirect_pc)
//   out_valid/ready  handshake towards decode; out_inst/out_pc at FIFO head
//   fault            sticky misaligned-redirect flag
module inst_fetch #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          MEM_LATENCY = 1,
   parameter int          IMEM_ADDR_W = 15
) (
   input  logic                   clk,
   input  logic                   rstn,
   output logic                   imem_en,
   output logic [IMEM_ADDR_W-1:0] imem_addr,
   input  logic [31:0]            imem_rdata,
   input  logic                   redirect_valid,
   input  logic [31:0]            redirect_pc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_inst,
   output logic [31:0]            out_pc,
   output logic                   fault
);

   localparam int DEPTH = MEM_LATENCY + 1;
   localparam int PTR_W = $clog2(DEPTH);
   // Wide enough to hold count + inflight (at most 2*DEPTH).
   localparam int CNT_W = $clog2(DEPTH + 1) + 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } fetch_entry_t;

   logic [31:0]                  pc_q;
   logic [MEM_LATENCY-1:0]       vld_pipe;
   logic [MEM_LATENCY-1:0][31:0] pc_pipe;
   fetch_entry_t                 fifo_mem [DEPTH];
   logic [PTR_W-1:0]             rd_ptr, wr_ptr;
   logic [CNT_W-1:0]             count, inflight;
   logic                         fault_q;
   logic                         issue, push, pop, flush;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < MEM_LATENCY; i++)
         inflight = inflight + CNT_W'(vld_pipe[i]);
   end

   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;
   assign push      = vld_pipe[MEM_LATENCY-1];
   // Once faulted, redirects are ignored entirely.
   assign flush     = redirect_valid && !fault_q;

   // Credit rule: every in-flight request already owns a FIFO slot, and a
   // pop in this cycle frees one for the request issued now.
   assign issue = rstn && !fault_q && !redirect_valid &&
                  (((count + inflight) < DEPTH_C) || pop);

   assign imem_en   = issue;
   assign imem_addr = pc_q[IMEM_ADDR_W+1:2];
   assign out_inst  = out_valid ? fifo_mem[rd_ptr].inst : 32'h0;
   assign out_pc    = out_valid ? fifo_mem[rd_ptr].pc   : 32'h0;
   assign fault     = fault_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         pc_q     <= RESET_PC;
         vld_pipe <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         fault_q  <= 1'b0;
      end else if (flush) begin
         // Killed tags are dropped, so their returning data never enqueues.
         pc_q     <= redirect_pc;
         vld_pipe <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         if (redirect_pc[1:0] != 2'b00)
            fault_q <= 1'b1;
      end else begin
         if (issue)
            pc_q <= pc_q + 32'd4;
         for (int i = MEM_LATENCY - 1; i > 0; i--)
            vld_pipe[i] <= vld_pipe[i-1];
         vld_pipe[0] <= issue;
         if (push)
            wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Datapath storage: contents are qualified by vld_pipe / count.
   always_ff @(posedge clk) begin
      for (int i = MEM_LATENCY - 1; i > 0; i--)
         pc_pipe[i] <= pc_pipe[i-1];
      pc_pipe[0] <= pc_q;
      if (push)
         fifo_mem[wr_ptr] <= '{inst: imem_rdata, pc: pc_pipe[MEM_LATENCY-1]};
   end

endmodule
